// File: rtl/alu_op_sequencer.sv
// Step-driven controller that sequences one ALU operation from shared switch input:
// opcode, operand A, operand B, execute for EXEC_CYCLES cycles, capture the result.
module alu_op_sequencer #(
   parameter int unsigned LENGTH_v    = 5,
   parameter int unsigned EXEC_CYCLES = 2,
   parameter int unsigned NUM_OPS     = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  step,
   input  logic                  abort,
   input  logic [LENGTH_v-1:0]   data_in,
   input  logic [2*LENGTH_v-1:0] result_in,
   output logic [LENGTH_v-1:0]   a_out,
   output logic [LENGTH_v-1:0]   b_out,
   output logic [3:0]            op_out,
   output logic                  alu_enable,
   output logic                  result_load,
   output logic [2*LENGTH_v-1:0] result_out,
   output logic [2:0]            state_out,
   output logic                  busy,
   output logic                  op_error
);

   localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(EXEC_CYCLES - 1);
   // Opcode space is 4 bits, so NUM_OPS fits in 5 bits.
   localparam logic [4:0] NumOps = 5'(NUM_OPS);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StGetA = 3'd1,
      StGetB = 3'd2,
      StExec = 3'd3,
      StCapt = 3'd4,
      StShow = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   logic                    step_q;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [LENGTH_v-1:0]     a_q, a_d;
   logic [LENGTH_v-1:0]     b_q, b_d;
   logic [3:0]              op_q, op_d;
   logic [2*LENGTH_v-1:0]   res_q, res_d;
   logic                    err_q, err_d;
   logic                    step_p;
   logic                    op_legal;

   // step_q resets high so a button held through reset does not count as a step.
   assign step_p   = step & ~step_q;
   assign op_legal = ({1'b0, data_in[3:0]} < NumOps);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         step_q  <= 1'b1;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = err_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (step_p) begin
                  if (op_legal) begin
                     op_d    = data_in[3:0];
                     err_d   = 1'b0;
                     state_d = StGetA;
                  end else begin
                     err_d   = 1'b1;
                  end
               end
            end
            StGetA: begin
               if (step_p) begin
                  a_d     = data_in;
                  state_d = StGetB;
               end
            end
            StGetB: begin
               if (step_p) begin
                  b_d     = data_in;
                  cnt_d   = '0;
                  state_d = StExec;
               end
            end
            StExec: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = StCapt;
               end
            end
            StCapt: begin
               res_d   = result_in;
               state_d = StShow;
            end
            StShow: begin
               if (step_p) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Strobes decode registered state only, so no input reaches them combinationally.
   always_comb begin
      alu_enable  = (state_q == StExec);
      result_load = (state_q == StCapt);
      busy        = (state_q == StExec) || (state_q == StCapt);
      state_out   = state_q;
      a_out       = a_q;
      b_out       = b_q;
      op_out      = op_q;
      result_out  = res_q;
      op_error    = err_q;
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_alu_op_sequencer;

   localparam int unsigned L  = 5;
   localparam int unsigned EC = 2;
   localparam int unsigned NO = 10;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           step  = 1'b0;
   logic           abort = 1'b0;
   logic [L-1:0]   data_in = '0;
   logic [2*L-1:0] result_in = '0;
   logic [L-1:0]   a_out, b_out;
   logic [3:0]     op_out;
   logic           alu_enable, result_load, busy, op_error;
   logic [2*L-1:0] result_out;
   logic [2:0]     state_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int             m_state = 0;
   int             m_left = 0;
   logic           m_prev = 1'b1;
   logic [L-1:0]   m_a = '0, m_b = '0;
   logic [3:0]     m_op = '0;
   logic [2*L-1:0] m_res = '0;
   logic           m_err = 1'b0;

   alu_op_sequencer #(.LENGTH_v(L), .EXEC_CYCLES(EC), .NUM_OPS(NO)) dut (
      .clock      (clock),
      .reset      (reset),
      .step       (step),
      .abort      (abort),
      .data_in    (data_in),
      .result_in  (result_in),
      .a_out      (a_out),
      .b_out      (b_out),
      .op_out     (op_out),
      .alu_enable (alu_enable),
      .result_load(result_load),
      .result_out (result_out),
      .state_out  (state_out),
      .busy       (busy),
      .op_error   (op_error)
   );

   always #5 clock = ~clock;

   // Model: 0 idle, 1 want A, 2 want B, 3 executing (m_left cycles remain), 4 capture, 5 show.
   task automatic model_update();
      logic p;
      if (reset) begin
         m_state = 0; m_left = 0; m_prev = 1'b1;
         m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0;
      end else begin
         p = step && !m_prev;
         m_prev = step;
         if (abort) begin
            m_state = 0;
         end else begin
            case (m_state)
               0: if (p) begin
                  if (int'(data_in[3:0]) < int'(NO)) begin
                     m_op = data_in[3:0]; m_err = 1'b0; m_state = 1;
                  end else begin
                     m_err = 1'b1;
                  end
               end
               1: if (p) begin m_a = data_in; m_state = 2; end
               2: if (p) begin m_b = data_in; m_left = EC; m_state = 3; end
               3: begin m_left = m_left - 1; if (m_left == 0) m_state = 4; end
               4: begin m_res = result_in; m_state = 5; end
               5: if (p) m_state = 0;
               default: m_state = 0;
            endcase
         end
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic ab,
                        input logic [L-1:0] d, input logic [2*L-1:0] res);
      reset = r; step = s; abort = ab; data_in = d; result_in = res;
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, '0);
      cycle(1'b1, 1'b1, 1'b1, '1, '1);
      vectors++;
      if (state_out !== 3'd0) begin
         miscompares++; $display("FAIL reset_state got %0d want 0", state_out);
      end
      vectors++;
      if ({a_out, b_out, op_out, result_out, op_error} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs got a=%0d b=%0d op=%0d res=%0h err=%0b want all 0",
                  a_out, b_out, op_out, result_out, op_error);
      end
      vectors++;
      if ({alu_enable, result_load, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_strobes got %b want 000", {alu_enable, result_load, busy});
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_basic_op();
      int en_cnt, ld_cnt;
      cycle(1'b0, 1'b1, 1'b0, 5'd2, '0);
      vectors++;
      if (state_out !== 3'd1 || op_out !== 4'd2) begin
         miscompares++; $display("FAIL basic_op got st=%0d op=%0d want 1/2", state_out, op_out);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 5'd5, '0);
      vectors++;
      if (state_out !== 3'd2 || a_out !== 5'd5) begin
         miscompares++; $display("FAIL basic_a got st=%0d a=%0d want 2/5", state_out, a_out);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h2A5);
      cycle(1'b0, 1'b1, 1'b0, 5'b11101, 10'h2A5);
      vectors++;
      if (state_out !== 3'd3 || b_out !== 5'd29 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_b got st=%0d b=%0d busy=%0b want 3/29/1", state_out, b_out, busy);
      end
      en_cnt = int'(alu_enable);
      ld_cnt = int'(result_load);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, 10'h2A5);
         en_cnt += int'(alu_enable);
         ld_cnt += int'(result_load);
         if (i == 1) begin
            vectors++;
            if (state_out !== 3'd4 || result_out !== 10'h000) begin
               miscompares++;
               $display("FAIL basic_capt got st=%0d res=%0h want 4/000", state_out, result_out);
            end
         end
         if (i == 2) begin
            vectors++;
            if (state_out !== 3'd5 || result_out !== 10'h2A5) begin
               miscompares++;
               $display("FAIL basic_show got st=%0d res=%0h want 5/2a5", state_out, result_out);
            end
         end
      end
      vectors++;
      if (en_cnt != int'(EC) || ld_cnt != 1) begin
         miscompares++;
         $display("FAIL basic_strobes got en=%0d ld=%0d want %0d/1", en_cnt, ld_cnt, EC);
      end
   endtask

   task automatic test_illegal_op();
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      vectors++;
      if (state_out !== 3'd0 || op_out !== 4'd2) begin
         miscompares++; $display("FAIL show_exit got st=%0d op=%0d want 0/2", state_out, op_out);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 5'd12, '0);
      vectors++;
      if (op_error !== 1'b1 || state_out !== 3'd0 || op_out !== 4'd2) begin
         miscompares++;
         $display("FAIL illegal_12 got err=%0b st=%0d op=%0d want 1/0/2", op_error, state_out,
                  op_out);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 5'b11010, '0);
      vectors++;
      if (op_error !== 1'b1 || state_out !== 3'd0) begin
         miscompares++;
         $display("FAIL illegal_10 got err=%0b st=%0d want 1/0", op_error, state_out);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 5'd9, '0);
      vectors++;
      if (op_error !== 1'b0 || state_out !== 3'd1 || op_out !== 4'd9) begin
         miscompares++;
         $display("FAIL legal_9 got err=%0b st=%0d op=%0d want 0/1/9", op_error, state_out,
                  op_out);
      end
      cycle(1'b0, 1'b0, 1'b1, '0, '0);
      vectors++;
      if (state_out !== 3'd0 || op_out !== 4'd9) begin
         miscompares++; $display("FAIL abort_idle got st=%0d op=%0d want 0/9", state_out, op_out);
      end
   endtask

   task automatic test_held_step();
      int moved;
      moved = 0;
      cycle(1'b1, 1'b1, 1'b0, 5'd4, '0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 5'd4, '0);
         if (state_out !== 3'd0) moved++;
      end
      vectors++;
      if (moved != 0) begin
         miscompares++; $display("FAIL held_step got %0d moved cycles want 0", moved);
      end
      cycle(1'b0, 1'b0, 1'b0, 5'd4, '0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 5'd4, '0);
      vectors++;
      if (state_out !== 3'd1 || op_out !== 4'd4) begin
         miscompares++;
         $display("FAIL held_one_step got st=%0d op=%0d want 1/4", state_out, op_out);
      end
      cycle(1'b0, 1'b0, 1'b1, '0, '0);
   endtask

   task automatic test_ignore_steps();
      logic [2*L-1:0] res;
      for (int run = 0; run < 2; run++) begin
         res = (run == 0) ? 10'h155 : 10'h0AA;
         cycle(1'b0, 1'b0, 1'b0, '0, res);
         cycle(1'b0, 1'b1, 1'b0, 5'd1, res);
         cycle(1'b0, 1'b0, 1'b0, '0, res);
         cycle(1'b0, 1'b1, 1'b0, 5'd7, res);
         cycle(1'b0, 1'b0, 1'b0, '0, res);
         cycle(1'b0, 1'b1, 1'b0, 5'd9, res);
         cycle(1'b0, 1'b0, 1'b0, '0, res);
         if (run == 0) begin
            cycle(1'b0, 1'b1, 1'b0, '0, res);
            vectors++;
            if (state_out !== 3'd4) begin
               miscompares++; $display("FAIL exec_step got st=%0d want 4", state_out);
            end
         end else begin
            cycle(1'b0, 1'b0, 1'b0, '0, res);
            cycle(1'b0, 1'b1, 1'b0, '0, res);
         end
         cycle(1'b0, 1'b1, 1'b0, '0, res);
         cycle(1'b0, 1'b1, 1'b0, '0, res);
         vectors++;
         if (state_out !== 3'd5 || result_out !== res) begin
            miscompares++;
            $display("FAIL ignore_run%0d got st=%0d res=%0h want 5/%0h", run, state_out,
                     result_out, res);
         end
         cycle(1'b0, 1'b0, 1'b0, '0, '0);
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
   endtask

   task automatic test_abort();
      int loads;
      loads = 0;
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h3FF);
      cycle(1'b0, 1'b1, 1'b0, 5'd3, 10'h3FF);
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h3FF);
      cycle(1'b0, 1'b1, 1'b0, 5'd11, 10'h3FF);
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h3FF);
      cycle(1'b0, 1'b1, 1'b0, 5'd13, 10'h3FF);
      cycle(1'b0, 1'b1, 1'b1, 5'd13, 10'h3FF);
      vectors++;
      if (state_out !== 3'd0 || alu_enable !== 1'b0 || result_load !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_exec got st=%0d en=%0b ld=%0b want 0/0/0", state_out, alu_enable,
                  result_load);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, 10'h3FF);
         loads += int'(result_load);
      end
      vectors++;
      if (loads != 0 || result_out !== 10'h0AA || state_out !== 3'd0) begin
         miscompares++;
         $display("FAIL abort_after got loads=%0d res=%0h st=%0d want 0/0aa/0", loads,
                  result_out, state_out);
      end
      cycle(1'b0, 1'b1, 1'b0, 5'd2, '0);
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b1, 5'd17, '0);
      vectors++;
      if (state_out !== 3'd0 || a_out !== 5'd11) begin
         miscompares++;
         $display("FAIL abort_beats_step got st=%0d a=%0d want 0/11", state_out, a_out);
      end
   endtask

   task automatic test_reset_in_show();
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h123);
      cycle(1'b0, 1'b1, 1'b0, 5'd1, 10'h123);
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h123);
      cycle(1'b0, 1'b1, 1'b0, 5'd3, 10'h123);
      cycle(1'b0, 1'b0, 1'b0, '0, 10'h123);
      cycle(1'b0, 1'b1, 1'b0, 5'd4, 10'h123);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, 10'h123);
      vectors++;
      if (state_out !== 3'd5 || result_out !== 10'h123) begin
         miscompares++;
         $display("FAIL pre_reset got st=%0d res=%0h want 5/123", state_out, result_out);
      end
      cycle(1'b1, 1'b1, 1'b1, '1, '1);
      vectors++;
      if ({state_out, a_out, b_out, op_out, result_out, op_error, alu_enable, result_load, busy}
          !== '0) begin
         miscompares++;
         $display("FAIL reset_show got st=%0d a=%0d b=%0d op=%0d res=%0h err=%0b en=%0b want 0",
                  state_out, a_out, b_out, op_out, result_out, op_error, alu_enable);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_random();
      logic [39:0] got, exp;
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), L'($urandom), (2*L)'($urandom));
         got = {3'(state_out), a_out, b_out, op_out, result_out, op_error, alu_enable,
                result_load, busy, 4'h0};
         exp = {3'(m_state), m_a, m_b, m_op, m_res, m_err, (m_state == 3), (m_state == 4),
                (m_state == 3 || m_state == 4), 4'h0};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random_cycle%0d got %h want %h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_op();
      test_illegal_op();
      test_held_step();
      test_ignore_steps();
      test_abort();
      test_reset_in_show();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
